// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU among four requesters, one operation in flight.
// Sin/cos spend an extra cycle reading the table before the ALU cycle.
module alu_arbiter #(
  parameter int N = 24,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  input  logic [4*R-1:0] req_op,
  input  logic [N*R-1:0] req_a,
  input  logic [N*R-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_select,
  input  logic [N-1:0]   alu_out,
  output logic [N-1:0]   lut_addr,
  output logic           lut_rd,
  output logic           rsp_valid,
  output logic [1:0]     rsp_id,
  output logic [N-1:0]   rsp_data,
  output logic           rsp_err,
  input  logic           rsp_ready
);
  // state | meaning: IDLE grant | LUT table read | EXEC drive ALU, capture result | RESP hold response
  typedef enum logic [1:0] {IDLE, LUT, EXEC, RESP} state_t;

  localparam logic [3:0] OP_MOV = 4'b1010;
  localparam logic [3:0] OP_SIN = 4'b1011;
  localparam logic [3:0] OP_COS = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1111;

  state_t       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]   id_q, id_d, rr_q, rr_d;
  logic         rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_data_q, rsp_data_d;
  logic         lut_rd_q, lut_rd_d;
  logic [N-1:0] lut_addr_q, lut_addr_d;
  logic [N-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]   alu_select_q, alu_select_d;

  logic         grant_found;
  logic [1:0]   grant_id, scan_id;
  logic [3:0]   grant_op;
  logic [N-1:0] grant_a, grant_b;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_q;
    scan_id     = rr_q;
    for (int k = 0; k < 4; k++) begin
      scan_id = rr_q + 2'(k);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
    grant_op  = req_op[4*int'(grant_id) +: 4];
    grant_a   = req_a[N*int'(grant_id) +: N];
    grant_b   = req_b[N*int'(grant_id) +: N];
    req_ready = (state_q == IDLE && grant_found) ? (R'(1) << grant_id) : '0;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_d    = grant_op;
          a_d     = grant_a;
          b_d     = grant_b;
          id_d    = grant_id;
          rr_d    = grant_id + 2'd1;
          state_d = (grant_op == OP_SIN || grant_op == OP_COS) ? LUT : EXEC;
        end
      end
      LUT: state_d = EXEC;
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        state_d     = RESP;
        if (op_q < OP_MOV) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else if (op_q == OP_DIV && b_q == '0) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // ALU/table outputs are registered, so derive them from the state being entered
    lut_rd_d     = (state_d == LUT);
    lut_addr_d   = (state_d == LUT || state_d == EXEC) ? a_d : '0;
    alu_a_d      = (state_d == EXEC) ? a_d : '0;
    alu_b_d      = (state_d == EXEC) ? b_d : '0;
    alu_select_d = (state_d == EXEC) ? op_d : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rr_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      lut_rd_q     <= 1'b0;
      lut_addr_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rr_q         <= rr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      lut_rd_q     <= lut_rd_d;
      lut_addr_q   <= lut_addr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_select_q <= alu_select_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign lut_rd     = lut_rd_q;
  assign lut_addr   = lut_addr_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_select_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 24: operand/result width in bits.
REQ-002 SHALL have parameter R, default 4: number of requesters, fixed at 4; a 2-bit ID is sufficient.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, R: per-requester operation request.
REQ-006 SHALL have port req_op, input, 4*R: per-requester opcode (1010 mov, 1011 sin, 1100 cos, 1101 add, 1110 mult, 1111 div); requester i uses bits [4i+3:4i].
REQ-007 SHALL have port req_a, input, N*R: per-requester operand a.
REQ-008 SHALL have port req_b, input, N*R: per-requester operand b.
REQ-009 SHALL have port req_ready, output, R: one-hot grant; a request is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-010 SHALL have port alu_a, output, N: operand a to the shared ALU element.
REQ-011 SHALL have port alu_b, output, N: operand b to the shared ALU element.
REQ-012 SHALL have port alu_select, output, 4: opcode to the shared ALU element.
REQ-013 SHALL have port alu_out, input, N: combinational ALU result.
REQ-014 SHALL have port lut_addr, output, N: sin/cos table address; equals the latched operand a.
REQ-015 SHALL have port lut_rd, output, 1: table read strobe; the table returns data one cycle later through the ALU sin/cos inputs.
REQ-016 SHALL have port rsp_valid, output, 1: a response is available.
REQ-017 SHALL have port rsp_id, output, 2: index of the requester the response belongs to.
REQ-018 SHALL have port rsp_data, output, N: registered result.
REQ-019 SHALL have port rsp_err, output, 1: 1 for an illegal opcode or a divide by zero.
REQ-020 SHALL have port rsp_ready, input, 1: consumer accepts the response.

Function
REQ-021 SHALL implement the FSM states IDLE, LUT, EXEC and RESP.
REQ-022 In IDLE, SHALL assert req_ready for exactly one requester with req_valid=1, selected round-robin starting at rr_ptr; on acceptance, latch op/a/b/id, set rr_ptr = id+1 mod 4, then go to LUT if op is 1011 or 1100, otherwise to EXEC.
REQ-023 SHALL hold req_ready at 0 in every state other than IDLE (one operation in flight).
REQ-024 In LUT, SHALL assert lut_rd=1 for one cycle and then go to EXEC.
REQ-025 SHALL drive lut_addr from latched a in LUT and EXEC, and SHALL drive it to 0 otherwise.
REQ-026 In EXEC, SHALL drive alu_a, alu_b and alu_select from the latched values; at the end of the cycle, register rsp_data and rsp_err, then go to RESP.
REQ-027 Outside EXEC, SHALL drive alu_a, alu_b and alu_select to 0.
REQ-028 For op 1111 with b=0, SHALL set rsp_data to all ones and rsp_err=1.
REQ-029 For op 0000-1001, SHALL skip LUT, set rsp_data=0 and rsp_err=1 in EXEC; the ALU output is ignored.
REQ-030 In RESP, SHALL hold rsp_valid=1 with stable rsp_id, rsp_data and rsp_err until rsp_ready=1, then return to IDLE.
REQ-031 SHALL allow a new grant in the cycle after the RESP handshake, not in the same cycle.
REQ-032 Latency, grant cycle = T:
 - non-trig ops: rsp_valid first at T+2;
 - sin/cos: rsp_valid first at T+3.
REQ-033 SHALL take results modulo 2^N; the product is truncated to N LSBs and division is unsigned, exactly as the ALU provides.
REQ-034 SHALL keep rr_ptr unchanged in cycles with no grant.
REQ-035 A requester that drops req_valid before it is granted SHALL lose its place; no request is stored.

Reset
REQ-036 While rst_n=0, SHALL immediately (asynchronously) force:
 - state to IDLE and rr_ptr to 0;
 - rsp_valid, rsp_err, rsp_id and rsp_data to 0;
 - lut_rd, alu_a, alu_b and alu_select to 0.
REQ-037 Reset asserted mid-operation SHALL discard the in-flight operation with no response.
REQ-038 After rst_n rises, the first grant SHALL go to the lowest-indexed valid requester at or after index 0.

Verification
REQ-039 Bench SHALL cover: req_valid=0001, op 1101, a=5, b=7; grant at T -> rsp_valid at T+2, id=0, data=12, err=0.
REQ-040 Bench SHALL cover: req_valid=1111 held with add ops -> grants in order 0,1,2,3,0; each gets exactly one response.
REQ-041 Bench SHALL cover: op 1011, a=3 -> lut_rd=1 with lut_addr=3 at T+1; rsp_data = table sin value at T+3.
REQ-042 Bench SHALL cover: op 1111, a=10, b=0 -> data=0xFFFFFF, err=1; op 0100 -> data=0, err=1.
REQ-043 Bench SHALL cover: rsp_ready held at 0 for 5 cycles -> rsp_* stable and req_ready=0000; grant occurs the cycle after the handshake.
REQ-044 Bench SHALL cover: rst_n pulled low in EXEC -> rsp_valid=0 immediately; after release, requests 0100 and 0010 valid -> grant to requester 1.
